present_cipher_core: RTL and testbench
======================================

// Module: present_cipher_core
// PURPOSE
//  Iterative PRESENT block cipher core, one round per clock. Key width is a parameter (80 or 128).
//  Four-phase req/ack handshake to the host. Decryption is optional, via a macro.
//  Next generation of the team's iterative encrypt block; drop-in at the crypto-unit datapath.
// PARAMETERS
//  KEY_W    80   key width, legal values 80 or 128; any other value is an elaboration error
//  ROUNDS   31   round count; the final key addition uses K_(ROUNDS+1)
// PORTS
//  clk    in   1      single clock, all state on posedge
//  rst_n  in   1      asynchronous, active-low reset
//  req    in   1      request; held high for the whole transaction
//  ack    out  1      result valid; high until req falls
//  mode   in   1      0=encrypt, 1=decrypt; sampled with M/K
//  K      in   KEY_W  key, sampled at start
//  M      in   64     input block (plaintext or ciphertext), sampled at start
//  C      out  64     output block, registered, valid while ack=1
//  busy   out  1      high while the core is in any state except IDLE or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ack=0, busy=0, C=64'h0, round ctr=0, internal state/key regs=0.
//  Round (enc): s = pLayer(sBox(s ^ k[KEY_W-1 -: 64])); k = ks_update(k, i); i runs 1..ROUNDS.
//  ks_update 80: rotl 61; S-box on [79:76]; [19:15] ^= i.
//  ks_update 128: rotl 61; S-box on [127:124] and [123:120]; [66:62] ^= i.
//  FSM:
//   IDLE: req=1 captures M, K, mode; ctr=1; goes to ENC (mode=0) or KEYF (mode=1).
//   ENC: one round per edge. After the round with ctr==ROUNDS: C <= s ^ k_top64, ack <= 1, go to DONE.
//   KEYF: forward key schedule only, ROUNDS edges, ends with k=K_(ROUNDS+1).
//     Last edge: s <= M ^ k_top64; ctr <= ROUNDS; go to DEC.
//   DEC: per edge: k <= ks_inverse(k, ctr); s <= invS(invP(s)) ^ k_prev_top64 of K_ctr.
//     At ctr==1: C <= result, ack <= 1, go to DONE.
//     ks_inverse: xor ctr into the field; invS on the top nibble(s); rotr 61.
//   DONE: hold C and ack=1 while req=1. req=0 -> ack <= 0, go to IDLE.
//  Latency: encrypt, ack high at the (ROUNDS+1)th posedge after the capture edge (32 for the defaults).
//    Decrypt: 2*ROUNDS+1 edges (63 for the defaults).
//  req=0 in ENC/KEYF/DEC: abort; go to IDLE on the next edge; ack stays 0; C is unchanged.
//  req held high after DONE->IDLE is impossible; a new transaction needs req low for at least 1 cycle.
//  M/K/mode changes during a transaction are ignored; only the capture edge counts.
//  rst_n low mid-operation: immediate return to reset values; no partial result is shown.
//  C changes only on DONE entry or reset.
// CONFIGURATION
//  DECRYPT_EN defined: KEYF/DEC states, inverse S-box/pLayer and ks_inverse are built; mode is honoured.
//  DECRYPT_EN undefined: no inverse logic; mode is ignored (always encrypt); KEYF/DEC unreachable/absent.
// STRUCTURE
//  present_pkg: SBOX/INV_SBOX tables as functions; p_layer/inv_p_layer functions.
//    Also: state encoding localparams; KEY_W legality constants.
//  Sub-module present_key_sched: combinational ks_update / ks_inverse for KEY_W, selectable by direction.
//  Top: FSM, round counter, state/key/C registers.
// TESTING
//  KEY_W=80, K=0, M=0, enc -> ack after 32 edges, C=64'h5579C1387B228445.
//  KEY_W=80, K=all-1s, M=all-1s, enc -> C=64'h3333DCD3213210D2.
//  KEY_W=80, K=all-1s, M=0 -> C=64'hE72C46C0F5945049.
//    DECRYPT_EN: mode=1 with M=that C -> C=0 after 63 edges.
//  KEY_W=128, K=0, M=0, enc -> C=64'h96DB702A2E6900AF.
//  Drop req at edge 10 of ENC -> IDLE next edge, ack never rises, C unchanged.
//    A new req then gives the correct result.
//  rst_n pulsed low mid-DEC -> ack=0, busy=0, C=0 asynchronously.
//    Also: M changed during ENC has no effect on C.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box and bit-permutation layers, FSM state encoding, key width constants.
// Inverse layers are only referenced when DECRYPT_EN is defined.
package present_pkg;

    localparam int KEY_W_80  = 80;
    localparam int KEY_W_128 = 128;
    localparam int BLOCK_W   = 64;
    localparam int RC_W      = 5;
    localparam int CTR_W     = RC_W + 1;
    localparam int STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_ENC  = 3'd1,
        ST_KEYF = 3'd2,
        ST_DEC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic key_w_legal(input int w);
        return (w == KEY_W_80) || (w == KEY_W_128);
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            4'hF: y = 4'hA;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_s_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays in place.
    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(i * 16) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(i * 16) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_key_sched.sv
// Combinational PRESENT key schedule step for 80- or 128-bit keys.
// With DECRYPT_EN defined a dir_i port selects the inverse step (undo round-constant xor, inverse S-box, rotate right 61).
module present_key_sched
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
`ifdef DECRYPT_EN
    input  logic             dir_i,
`endif
    input  logic [KEY_W-1:0] key_i,
    input  logic [RC_W-1:0]  round_i,
    output logic [KEY_W-1:0] key_o
);

    localparam int RC_LO = (KEY_W == KEY_W_128) ? 62 : 15;

    logic [KEY_W-1:0] fwd_rot;
    logic [KEY_W-1:0] fwd_key;

    always_comb begin
        fwd_rot = {key_i[KEY_W-62:0], key_i[KEY_W-1:KEY_W-61]};
        fwd_key = fwd_rot;
        fwd_key[KEY_W-1 -: 4] = sbox(fwd_rot[KEY_W-1 -: 4]);
        if (KEY_W == KEY_W_128) begin
            fwd_key[KEY_W-5 -: 4] = sbox(fwd_rot[KEY_W-5 -: 4]);
        end
        fwd_key[RC_LO +: RC_W] = fwd_rot[RC_LO +: RC_W] ^ round_i;
    end

`ifdef DECRYPT_EN
    logic [KEY_W-1:0] inv_pre;
    logic [KEY_W-1:0] inv_key;

    // The constant field and the S-boxed nibbles never overlap, so undoing them in either order is exact.
    always_comb begin
        inv_pre = key_i;
        inv_pre[RC_LO +: RC_W] = key_i[RC_LO +: RC_W] ^ round_i;
        inv_pre[KEY_W-1 -: 4] = inv_sbox(key_i[KEY_W-1 -: 4]);
        if (KEY_W == KEY_W_128) begin
            inv_pre[KEY_W-5 -: 4] = inv_sbox(key_i[KEY_W-5 -: 4]);
        end
        inv_key = {inv_pre[60:0], inv_pre[KEY_W-1:61]};
    end

    assign key_o = dir_i ? inv_key : fwd_key;
`else
    assign key_o = fwd_key;
`endif

endmodule

// File: rtl/present_cipher_core.sv
// Iterative PRESENT cipher, one round per clock, four-phase req/ack host handshake.
// Define DECRYPT_EN to build the decrypt path (KEYF/DEC states); otherwise mode is ignored.
//
//   state | meaning
//   IDLE  | waiting for req; captures M, K, mode
//   ENC   | encryption rounds, then final key whitening
//   KEYF  | forward key schedule up to K_(ROUNDS+1)
//   DEC   | inverse rounds with reversed key schedule
//   DONE  | result on C, ack high until req falls
module present_cipher_core
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    output logic               ack,
    input  logic               mode,
    input  logic [KEY_W-1:0]   K,
    input  logic [BLOCK_W-1:0] M,
    output logic [BLOCK_W-1:0] C,
    output logic               busy
);

    if (!key_w_legal(KEY_W)) begin : g_key_w_check
        $error("present_cipher_core: KEY_W must be 80 or 128");
    end

    localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(ROUNDS);
    localparam logic [CTR_W-1:0] CTR_WHITE = CTR_W'(ROUNDS + 1);

    state_t               state_q;
    logic [CTR_W-1:0]     ctr_q;
    logic [BLOCK_W-1:0]   s_q;
    logic [KEY_W-1:0]     k_q;
    logic [BLOCK_W-1:0]   c_q;
    logic                 ack_q;
    logic                 busy_q;

    logic [KEY_W-1:0]     k_d;
    logic [BLOCK_W-1:0]   k_top;
    logic [BLOCK_W-1:0]   k_d_top;
    logic [BLOCK_W-1:0]   enc_d;

    assign k_top   = k_q[KEY_W-1 -: BLOCK_W];
    assign k_d_top = k_d[KEY_W-1 -: BLOCK_W];
    assign enc_d   = p_layer(s_layer(s_q ^ k_top));

    present_key_sched #(
        .KEY_W (KEY_W)
    ) u_key_sched (
`ifdef DECRYPT_EN
        .dir_i   (state_q == ST_DEC),
`endif
        .key_i   (k_q),
        .round_i (ctr_q[RC_W-1:0]),
        .key_o   (k_d)
    );

`ifdef DECRYPT_EN
    logic [BLOCK_W-1:0] dec_d;
    assign dec_d = inv_s_layer(inv_p_layer(s_q)) ^ k_d_top;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            c_q     <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        s_q    <= M;
                        k_q    <= K;
                        ctr_q  <= CTR_ONE;
                        busy_q <= 1'b1;
`ifdef DECRYPT_EN
                        state_q <= mode ? ST_KEYF : ST_ENC;
`else
                        state_q <= ST_ENC;
`endif
                    end
                end

                ST_ENC: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (ctr_q == CTR_WHITE) begin
                        c_q     <= s_q ^ k_top;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        s_q   <= enc_d;
                        k_q   <= k_d;
                        ctr_q <= ctr_q + CTR_ONE;
                    end
                end

`ifdef DECRYPT_EN
                ST_KEYF: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        k_q <= k_d;
                        if (ctr_q == CTR_LAST) begin
                            // s_q still holds the captured ciphertext
                            s_q     <= s_q ^ k_d_top;
                            ctr_q   <= CTR_LAST;
                            state_q <= ST_DEC;
                        end else begin
                            ctr_q <= ctr_q + CTR_ONE;
                        end
                    end
                end

                ST_DEC: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (ctr_q == '0) begin
                        c_q     <= s_q;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        s_q   <= dec_d;
                        k_q   <= k_d;
                        ctr_q <= ctr_q - CTR_ONE;
                    end
                end
`endif

                ST_DONE: begin
                    if (!req) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack  = ack_q;
    assign C    = c_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_present_cipher_core.sv
// Scoreboard bench for present_cipher_core: an 80-bit and a 128-bit instance, checked against a loop-based PRESENT model.
// Decrypt vectors are exercised only when DECRYPT_EN is defined.
module tb_present_cipher_core;

    localparam int ROUNDS = 31;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    typedef struct {
        logic [63:0] c;
        int          lat;
        int          cap;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req   [2];
    logic         ack   [2];
    logic         busy  [2];
    logic         mode  [2];
    logic [63:0]  m     [2];
    logic [63:0]  c     [2];
    logic [127:0] kk    [2];
    logic         ack_prev [2];
    logic [63:0]  last_c [2];

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present_cipher_core #(.KEY_W(80), .ROUNDS(ROUNDS)) dut80 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .ack(ack[0]), .mode(mode[0]),
        .K(kk[0][79:0]), .M(m[0]), .C(c[0]), .busy(busy[0])
    );

    present_cipher_core #(.KEY_W(128), .ROUNDS(ROUNDS)) dut128 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .ack(ack[1]), .mode(mode[1]),
        .K(kk[1]), .M(m[1]), .C(c[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] sb_inv(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++) if (SB[v] == x) r = 4'(v);
        return r;
    endfunction

    function automatic int perm(input int i);
        return (i == 63) ? 63 : (i * 16) % 63;
    endfunction

    // Reference: expand all round keys, then run the round loop forward or backward.
    function automatic logic [63:0] ref_cipher(input logic [127:0] key, input int kw,
                                               input logic [63:0] blk, input logic dec);
        logic [127:0] k;
        logic [63:0]  rk [1:ROUNDS+1];
        logic [63:0]  s;
        logic [63:0]  t;
        k = key;
        for (int r = 1; r <= ROUNDS + 1; r++) begin
            if (kw == 80) begin
                rk[r] = k[79:16];
                k[79:0] = {k[18:0], k[79:19]};
                k[79:76] = SB[k[79:76]];
                k[19:15] = k[19:15] ^ 5'(r);
            end else begin
                rk[r] = k[127:64];
                k = {k[66:0], k[127:67]};
                k[127:124] = SB[k[127:124]];
                k[123:120] = SB[k[123:120]];
                k[66:62] = k[66:62] ^ 5'(r);
            end
        end
        if (!dec) begin
            s = blk;
            for (int r = 1; r <= ROUNDS; r++) begin
                s = s ^ rk[r];
                for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
                t = '0;
                for (int i = 0; i < 64; i++) t[perm(i)] = s[i];
                s = t;
            end
            return s ^ rk[ROUNDS+1];
        end
        s = blk ^ rk[ROUNDS+1];
        for (int r = ROUNDS; r >= 1; r--) begin
            t = '0;
            for (int i = 0; i < 64; i++) t[i] = s[perm(i)];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = sb_inv(t[4*n +: 4]);
            s = t ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic eff_dec(input logic md);
`ifdef DECRYPT_EN
        return md;
`else
        return 1'b0;
`endif
    endfunction

    // Full transaction; the expected result goes to the scoreboard, the monitor checks it.
    task automatic txn(input int d, input logic [127:0] key, input logic [63:0] blk,
                       input logic md, input logic [63:0] exp_c);
        exp_t e;
        int   n;
        @(negedge clk);
        kk[d] = key;
        m[d] = blk;
        mode[d] = md;
        req[d] = 1'b1;
        e.c = exp_c;
        e.lat = eff_dec(md) ? 2 * ROUNDS + 1 : ROUNDS + 1;
        e.cap = cyc + 1;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        @(negedge clk);
        chk("busy_running", 64'(busy[d]), 64'd1);
        m[d] = {$urandom, $urandom};
        kk[d] = {$urandom, $urandom, $urandom, $urandom};
        mode[d] = ~md;
        n = 0;
        while (!ack[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ack[d]) chk("ack_timeout", 64'(ack[d]), 64'd1);
        chk("busy_done", 64'(busy[d]), 64'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk("c_hold", c[d], exp_c);
        req[d] = 1'b0;
        @(negedge clk);
        chk("ack_release", 64'(ack[d]), 64'd0);
        last_c[d] = exp_c;
    endtask

    task automatic rand_txn(input int d);
        logic [127:0] key;
        logic [63:0]  blk;
        logic         md;
        int           kw;
        key = {$urandom, $urandom, $urandom, $urandom};
        blk = {$urandom, $urandom};
        md = 1'($urandom_range(0, 1));
        kw = (d == 0) ? 80 : 128;
        if (kw == 80) key[127:80] = '0;
        txn(d, key, blk, md, ref_cipher(key, kw, blk, eff_dec(md)));
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] && !ack_prev[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk("unexpected_ack", 64'(ack[d]), 64'd0);
                end else begin
                    if (d == 0) mon_e = q0.pop_front();
                    else mon_e = q1.pop_front();
                    chk("result_c", c[d], mon_e.c);
                    chk("latency", 64'(cyc - mon_e.cap), 64'(mon_e.lat));
                end
            end
            ack_prev[d] = ack[d];
        end
    end

    initial begin
        logic [63:0] ones64;
        ones64 = '1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; mode[d] = 1'b0; m[d] = '0; kk[d] = '0;
            ack_prev[d] = 1'b0; last_c[d] = '0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", 64'(ack[d]), 64'd0);
            chk("reset_busy", 64'(busy[d]), 64'd0);
            chk("reset_c", c[d], 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        txn(0, 128'd0, 64'd0, 1'b0, 64'h5579C1387B228445);
        txn(0, {48'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF}, ones64, 1'b0, 64'h3333DCD3213210D2);
        txn(0, {48'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF}, 64'd0, 1'b0, 64'hE72C46C0F5945049);
`ifdef DECRYPT_EN
        txn(0, {48'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF}, 64'hE72C46C0F5945049, 1'b1, 64'd0);
`endif
        txn(1, 128'd0, 64'd0, 1'b0, 64'h96DB702A2E6900AF);

        // Abort after ten ENC-phase edges: no ack, C keeps the previous result.
        @(negedge clk);
        kk[0] = {48'd0, $urandom, $urandom, 16'h5A5A};
        m[0] = {$urandom, $urandom};
        mode[0] = 1'b0;
        req[0] = 1'b1;
        repeat (10) @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_ack", 64'(ack[0]), 64'd0);
        chk("abort_c", c[0], last_c[0]);
        repeat (40) @(negedge clk);
        chk("abort_c_later", c[0], last_c[0]);
        txn(0, 128'd0, 64'd0, 1'b0, 64'h5579C1387B228445);

        for (int i = 0; i < 16; i++) rand_txn(0);
        for (int i = 0; i < 6; i++) rand_txn(1);

        // Asynchronous reset in the middle of a transaction.
        @(negedge clk);
        kk[0] = {48'd0, $urandom, $urandom, 16'h1234};
        m[0] = {$urandom, $urandom};
        mode[0] = 1'b1;
        req[0] = 1'b1;
        repeat (eff_dec(1'b1) ? 40 : 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 64'(ack[0]), 64'd0);
        chk("rst_mid_busy", 64'(busy[0]), 64'd0);
        chk("rst_mid_c", c[0], 64'd0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_c[0] = '0;
        last_c[1] = '0;
        chk("post_rst_c", c[0], 64'd0);

        rand_txn(0);
        rand_txn(1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
